param_data_memory: RTL and testbench

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 56 +++++
 tb/tb_param_data_memory.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// param_data_memory: word-addressed memory with a preload sweep after reset and a registered read port
// Ports: clock, reset (async, active-high); memWrite/memRead/addressMem/dataMem request inputs;
// memOut registered read data, readValid marks the cycle after an accepted read, busy high during the sweep.
module param_data_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter logic [DATA_W-1:0] INIT0 = DATA_W'(7),
  parameter logic [DATA_W-1:0] INIT1 = DATA_W'(8'b010_00000),
  parameter logic [DATA_W-1:0] INIT2 = DATA_W'(0)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic [ADDR_W-1:0] addressMem,
  input  logic [DATA_W-1:0] dataMem,
  output logic [DATA_W-1:0] memOut,
  output logic              readValid,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [ADDR_W:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_val;
  logic ready;
  assign ready = state == READY;
  assign busy = !ready;
  always_comb
    init_val = cnt == (ADDR_W+1)'(0) ? INIT0 :
               cnt == (ADDR_W+1)'(1) ? INIT1 :
               cnt == (ADDR_W+1)'(2) ? INIT2 : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= INIT;
      cnt <= '0;
    end else if (!ready) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= READY;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      memOut <= '0;
      readValid <= 1'b0;
    end else begin
      readValid <= ready && memRead;
      if (ready && memRead) memOut <= mem[addressMem];
    end
  // no reset on the array: contents change only through the sweep or user writes
  always_ff @(posedge clock)
    if (!ready) mem[cnt[ADDR_W-1:0]] <= init_val;
    else if (memWrite) mem[addressMem] <= dataMem;
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: scoreboard bench for param_data_memory with ADDR_W=4
module tb_param_data_memory;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic memWrite = 1'b0;
  logic memRead = 1'b0;
  logic [3:0] addressMem = '0;
  logic [7:0] dataMem = '0;
  logic [7:0] memOut;
  logic readValid;
  logic busy;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pre [16];

  param_data_memory #(.ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .memWrite(memWrite), .memRead(memRead),
    .addressMem(addressMem), .dataMem(dataMem), .memOut(memOut),
    .readValid(readValid), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (readValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_readValid: got memOut=%0h with no read pending at %0t", memOut, $time);
      end else chk("memOut", memOut, exp_q.pop_front());
    end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    memRead = 1'b1;
    addressMem = a;
    exp_q.push_back(e);
    step();
    chk("readValid_after_read", readValid, 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    memWrite = 1'b1;
    addressMem = a;
    dataMem = d;
    step();
    memWrite = 1'b0;
  endtask

  task automatic idle();
    memRead = 1'b0;
    memWrite = 1'b0;
    step();
    chk("readValid_idle", readValid, 0);
  endtask

  task automatic sweep();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("busy_sweep", busy, k < 16);
      if (k < 16) chk("memOut_hold_init", memOut, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) pre[i] = 8'h00;
    pre[0] = 8'h07;
    pre[1] = 8'h40;
    memRead = 1'b1;
    addressMem = 4'd0;
    step();
    step();
    chk("reset_busy", busy, 1);
    chk("reset_readValid", readValid, 0);
    chk("reset_memOut", memOut, 0);
    sweep();
    rd(4'd0, 8'h07);
    rd(4'd1, 8'h40);
    rd(4'd5, 8'h00);
    idle();
    chk("memOut_hold", memOut, 8'h00);
    wr(4'd9, 8'hA5);
    rd(4'd9, 8'hA5);
    idle();
    chk("memOut_hold_A5", memOut, 8'hA5);
    memWrite = 1'b1;
    dataMem = 8'h3C;
    rd(4'd3, 8'h00);
    memWrite = 1'b0;
    rd(4'd3, 8'h3C);
    idle();
    memWrite = 1'b1;
    dataMem = 8'h55;
    memRead = 1'b1;
    addressMem = 4'd4;
    exp_q.push_back(8'h00);
    step();
    memWrite = 1'b0;
    rd(4'd4, 8'h55);
    idle();
    wr(4'd0, 8'h11);
    rd(4'd0, 8'h11);
    idle();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 1);
    chk("midreset_readValid", readValid, 0);
    chk("midreset_memOut", memOut, 0);
    step();
    sweep();
    for (int i = 0; i < 16; i++) rd(4'(i), pre[i]);
    idle();
    rd(4'd2, 8'h00);
    rd(4'd15, 8'h00);
    rd(4'd0, 8'h07);
    idle();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
